// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types for the 5-stage MIPS core.
//   - word_t / regbits_t / aluop_t : basic datapath widths
//   - fwdsel_t + FWD_* codes       : forwarding-unit operand select encoding
//   - idex_state_t                 : ID/EX latch stall FSM states
//   - id_ex_t                      : everything held in the ID/EX register
//   - fwdSelect()                  : operand mux used ahead of the ID/EX latch
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W  = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 4;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [REG_W-1:0]   regbits_t;
    typedef logic [ALUOP_W-1:0] aluop_t;
    typedef logic [1:0]         fwdsel_t;

    // Forwarding select codes. 2'b11 is unused by the forwarding unit and
    // falls back to the register file value.
    localparam fwdsel_t FWD_REGFILE = 2'b00;
    localparam fwdsel_t FWD_EX      = 2'b01;
    localparam fwdsel_t FWD_MEM     = 2'b10;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } idex_state_t;

    typedef struct packed {
        logic     valid;
        regbits_t rs;
        regbits_t rt;
        regbits_t rd;
        logic     regWEN;
        logic     memRead;
        logic     memWrite;
        logic     aluSrc;
        aluop_t   aluop;
        word_t    opA;
        word_t    opB;
        word_t    imm;
    } id_ex_t;

    // A bubble carries no side effects; data fields are zeroed so the
    // execute stage sees a quiet, deterministic value.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    function automatic word_t fwdSelect(
        input fwdsel_t sel,
        input word_t   regVal,
        input word_t   exVal,
        input word_t   memVal
    );
        word_t result;
        case (sel)
            FWD_EX:  result = exVal;
            FWD_MEM: result = memVal;
            default: result = regVal;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/id_ex_latch_if.sv
// -----------------------------------------------------------------------------
// id_ex_latch_if
//   Bundles the ID/EX latch signals in the same shape as forwarding_unit_if.
//   Ports : CLK, RST (shared clock / asynchronous active-high reset)
//   Modports:
//     latch : the ID/EX register view (decode/forwarding in, execute out)
//     tb    : the driver view (decode/forwarding out, execute in)
// -----------------------------------------------------------------------------
interface id_ex_latch_if
    import cpu_types_pkg::*;
(
    input logic CLK,
    input logic RST
);
    logic     en;
    logic     flush;
    regbits_t Rs_dec;
    regbits_t Rt_dec;
    regbits_t Rd_dec;
    logic     usesRt_dec;
    logic     regWEN_dec;
    logic     memRead_dec;
    logic     memWrite_dec;
    logic     aluSrc_dec;
    aluop_t   aluop_dec;
    word_t    rdat1_dec;
    word_t    rdat2_dec;
    word_t    imm_dec;
    fwdsel_t  forwardA;
    fwdsel_t  forwardB;
    word_t    aluOut_ex;
    word_t    wdat_mem;

    regbits_t Rs_ex;
    regbits_t Rt_ex;
    regbits_t Rd_ex;
    logic     regWEN_ex;
    logic     memRead_ex;
    logic     memWrite_ex;
    logic     aluSrc_ex;
    aluop_t   aluop_ex;
    word_t    opA_ex;
    word_t    opB_ex;
    word_t    imm_ex;
    logic     valid_ex;
    logic     stall_dec;

    modport latch (
        input  CLK, RST, en, flush,
        input  Rs_dec, Rt_dec, Rd_dec, usesRt_dec,
        input  regWEN_dec, memRead_dec, memWrite_dec, aluSrc_dec, aluop_dec,
        input  rdat1_dec, rdat2_dec, imm_dec,
        input  forwardA, forwardB, aluOut_ex, wdat_mem,
        output Rs_ex, Rt_ex, Rd_ex,
        output regWEN_ex, memRead_ex, memWrite_ex, aluSrc_ex, aluop_ex,
        output opA_ex, opB_ex, imm_ex, valid_ex, stall_dec
    );

    modport tb (
        input  CLK, RST,
        output en, flush,
        output Rs_dec, Rt_dec, Rd_dec, usesRt_dec,
        output regWEN_dec, memRead_dec, memWrite_dec, aluSrc_dec, aluop_dec,
        output rdat1_dec, rdat2_dec, imm_dec,
        output forwardA, forwardB, aluOut_ex, wdat_mem,
        input  Rs_ex, Rt_ex, Rd_ex,
        input  regWEN_ex, memRead_ex, memWrite_ex, aluSrc_ex, aluop_ex,
        input  opA_ex, opB_ex, imm_ex, valid_ex, stall_dec
    );

endinterface

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
//   Purely combinational load-use hazard detector. Raises hz when the
//   instruction sitting in execute is a real load that writes a register the
//   decode-stage instruction is about to read.
//   Parameters: ZERO_REG - register index that never hazards
//   Inputs : validEx, memReadEx, regWenEx, rdEx  (execute-stage instruction)
//            rsDec, rtDec, usesRtDec             (decode-stage sources)
//   Output : hz
// -----------------------------------------------------------------------------
module load_use_detect
    import cpu_types_pkg::*;
#(
    parameter regbits_t ZERO_REG = 5'd0
) (
    input  logic     validEx,
    input  logic     memReadEx,
    input  logic     regWenEx,
    input  regbits_t rdEx,
    input  regbits_t rsDec,
    input  regbits_t rtDec,
    input  logic     usesRtDec,
    output logic     hz
);

    logic loadInEx;
    logic rsMatch;
    logic rtMatch;

    // Writes to ZERO_REG are discarded, so a load targeting it produces
    // nothing a consumer could wait for.
    assign loadInEx = validEx & memReadEx & regWenEx & (rdEx != ZERO_REG);
    assign rsMatch  = (rdEx == rsDec);
    // Rt only matters for instructions that actually read it (R-type, stores,
    // branches); I-type ALU ops reuse the Rt field as a destination.
    assign rtMatch  = usesRtDec & (rdEx == rtDec);

    assign hz = loadInEx & (rsMatch | rtMatch);

endmodule

// File: rtl/id_ex_latch.sv
// -----------------------------------------------------------------------------
// id_ex_latch
//   Decode-to-execute pipeline register of the 5-stage MIPS core.
//   - Muxes forwarded results into operands A/B before latching them.
//   - Detects load-use hazards, holds decode (stall_dec) and inserts
//     LOAD_STALL_CYCLES bubbles per hazard.
//   - Branch/jump flush squashes the decode instruction into a bubble and
//     overrides any pending stall.
//
// Parameters:
//   LOAD_STALL_CYCLES (1..7) bubbles per load-use hazard
//   ZERO_REG                 register index that never forwards or hazards
//
// Ports:
//   CLK, RST                      clock (rising edge), async active-high reset
//   en, flush                     pipeline advance, decode squash
//   *_dec                         decode-stage fields and register reads
//   forwardA/B, aluOut_ex,
//   wdat_mem                      forwarding selects and forwarded data
//   *_ex                          latched execute-stage fields
//   valid_ex                      execute slot holds a real instruction
//   stall_dec                     hold PC and IF/ID this cycle
//   stallCount (optional)         saturating count of hazard bubbles
//
// Build option:
//   IDEX_STALL_COUNT_EN  adds the stallCount output and its counter.
// -----------------------------------------------------------------------------
module id_ex_latch
    import cpu_types_pkg::*;
#(
    parameter int       LOAD_STALL_CYCLES = 1,
    parameter regbits_t ZERO_REG          = 5'd0
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     en,
    input  logic     flush,
    input  regbits_t Rs_dec,
    input  regbits_t Rt_dec,
    input  regbits_t Rd_dec,
    input  logic     usesRt_dec,
    input  logic     regWEN_dec,
    input  logic     memRead_dec,
    input  logic     memWrite_dec,
    input  logic     aluSrc_dec,
    input  aluop_t   aluop_dec,
    input  word_t    rdat1_dec,
    input  word_t    rdat2_dec,
    input  word_t    imm_dec,
    input  fwdsel_t  forwardA,
    input  fwdsel_t  forwardB,
    input  word_t    aluOut_ex,
    input  word_t    wdat_mem,
    output regbits_t Rs_ex,
    output regbits_t Rt_ex,
    output regbits_t Rd_ex,
    output logic     regWEN_ex,
    output logic     memRead_ex,
    output logic     memWrite_ex,
    output logic     aluSrc_ex,
    output aluop_t   aluop_ex,
    output word_t    opA_ex,
    output word_t    opB_ex,
    output word_t    imm_ex,
    output logic     valid_ex,
    output logic     stall_dec
`ifdef IDEX_STALL_COUNT_EN
    ,
    output word_t    stallCount
`endif
);

    // The hazard cycle itself latches the first bubble, so the counter only
    // has to cover the remaining LOAD_STALL_CYCLES-1 bubbles.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);

    id_ex_t      exReg;
    id_ex_t      exNext;
    id_ex_t      decodeFields;
    idex_state_t stateReg;
    idex_state_t stateNext;
    logic [2:0]  cntReg;
    logic [2:0]  cntNext;
    logic        hz;

    load_use_detect #(
        .ZERO_REG (ZERO_REG)
    ) u_load_use_detect (
        .validEx   (exReg.valid),
        .memReadEx (exReg.memRead),
        .regWenEx  (exReg.regWEN),
        .rdEx      (exReg.rd),
        .rsDec     (Rs_dec),
        .rtDec     (Rt_dec),
        .usesRtDec (usesRt_dec),
        .hz        (hz)
    );

    // Decode instruction as it would be latched, with forwarding applied.
    always_comb begin
        decodeFields          = ID_EX_BUBBLE;
        decodeFields.valid    = 1'b1;
        decodeFields.rs       = Rs_dec;
        decodeFields.rt       = Rt_dec;
        decodeFields.rd       = Rd_dec;
        decodeFields.regWEN   = regWEN_dec;
        decodeFields.memRead  = memRead_dec;
        decodeFields.memWrite = memWrite_dec;
        decodeFields.aluSrc   = aluSrc_dec;
        decodeFields.aluop    = aluop_dec;
        decodeFields.opA      = fwdSelect(forwardA, rdat1_dec, aluOut_ex, wdat_mem);
        decodeFields.opB      = fwdSelect(forwardB, rdat2_dec, aluOut_ex, wdat_mem);
        decodeFields.imm      = imm_dec;
    end

    // Next-state / next-register logic. Everything holds when en is low.
    always_comb begin
        exNext    = exReg;
        stateNext = stateReg;
        cntNext   = cntReg;

        if (en) begin
            if (flush) begin
                // Squash wins over any hazard or remaining bubbles: the
                // instruction that caused the stall is itself being discarded.
                exNext    = ID_EX_BUBBLE;
                stateNext = RUN;
                cntNext   = 3'd0;
            end else if (stateReg == BUBBLE) begin
                exNext = ID_EX_BUBBLE;
                if (cntReg == 3'd1) begin
                    stateNext = RUN;
                    cntNext   = 3'd0;
                end else begin
                    cntNext = cntReg - 3'd1;
                end
            end else if (hz) begin
                exNext = ID_EX_BUBBLE;
                if (MULTI_STALL) begin
                    stateNext = BUBBLE;
                    cntNext   = STALL_RELOAD;
                end else begin
                    stateNext = RUN;
                    cntNext   = 3'd0;
                end
            end else begin
                exNext = decodeFields;
            end
        end
    end

    // Decode must hold whenever a bubble is (or would be) latched for a
    // hazard, including cycles where en is low, so it never slips past.
    always_comb begin
        stall_dec = ~(en & flush) & (hz | (stateReg == BUBBLE));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exReg    <= ID_EX_BUBBLE;
            stateReg <= RUN;
            cntReg   <= 3'd0;
        end else begin
            exReg    <= exNext;
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    assign Rs_ex       = exReg.rs;
    assign Rt_ex       = exReg.rt;
    assign Rd_ex       = exReg.rd;
    assign regWEN_ex   = exReg.regWEN;
    assign memRead_ex  = exReg.memRead;
    assign memWrite_ex = exReg.memWrite;
    assign aluSrc_ex   = exReg.aluSrc;
    assign aluop_ex    = exReg.aluop;
    assign opA_ex      = exReg.opA;
    assign opB_ex      = exReg.opB;
    assign imm_ex      = exReg.imm;
    assign valid_ex    = exReg.valid;

`ifdef IDEX_STALL_COUNT_EN
    // Counts only hazard bubbles; flush bubbles are control-flow cost, not
    // load-use cost.
    logic  hazardBubble;
    word_t stallCountReg;

    assign hazardBubble = en & ~flush & (hz | (stateReg == BUBBLE));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stallCountReg <= '0;
        end else if (hazardBubble && (stallCountReg != '1)) begin
            stallCountReg <= stallCountReg + 32'd1;
        end
    end

    assign stallCount = stallCountReg;
`endif

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- Decode-to-execute pipeline register for the 5-stage MIPS core.
- Applies the forwarding unit's forwardA/forwardB selections to the decode-stage operands before latching them.
- Detects load-use hazards, stalls decode for LOAD_STALL_CYCLES, and injects bubbles.
- Its latched Rd_ex/regWEN_ex feed back to the forwarding unit and hazard logic.

Parameters:
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard, range 1..7.
- ZERO_REG, 5'd0: register index that never forwards or hazards.

Ports:
- CLK  in  1  core clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- en  in  1  pipeline advance enable (cache hit / not waiting).
- flush  in  1  squash decode instruction (branch/jump taken).
- Rs_dec, Rt_dec, Rd_dec  in  5 each  decode register indices.
- usesRt_dec  in  1  decode instruction reads Rt.
- regWEN_dec, memRead_dec, memWrite_dec, aluSrc_dec  in  1 each  decode controls.
- aluop_dec  in  4  ALU operation.
- rdat1_dec, rdat2_dec, imm_dec  in  32 each  register file reads and extended immediate.
- forwardA, forwardB  in  2 each  from forwarding unit: 00 regfile, 01 ex result, 10 mem result, 11 regfile.
- aluOut_ex  in  32  execute-stage ALU result.
- wdat_mem  in  32  memory-stage writeback data.
- Rs_ex, Rt_ex, Rd_ex  out  5 each  latched indices.
- regWEN_ex, memRead_ex, memWrite_ex, aluSrc_ex  out  1 each  latched controls.
- aluop_ex  out  4  latched ALU op.
- opA_ex, opB_ex, imm_ex  out  32 each  forwarded operand A, forwarded Rt value (also store data), immediate.
- valid_ex  out  1  execute slot holds a real instruction.
- stall_dec  out  1  hold PC and IF/ID this cycle.

Behaviour:
- Reset (async): all outputs 0; FSM to RUN; counter 0. Reset mid-stall drops the stall immediately.
- Operand select (combinational, pre-latch): opA_next = forwardA 01 ? aluOut_ex : 10 ? wdat_mem : rdat1_dec. opB_next uses the same selection on rdat2_dec with forwardB.
- Hazard: hz = valid_ex & memRead_ex & regWEN_ex & Rd_ex != ZERO_REG & (Rd_ex == Rs_dec | (usesRt_dec & Rd_ex == Rt_dec)).
- FSM states RUN and BUBBLE; cnt is 3 bits.
- RUN, en=1, hz=0, flush=0: latch decode fields with valid_ex=1. Latency is 1 cycle.
- RUN, en=1, hz=1: stall_dec=1 combinationally. Latch a bubble (valid_ex=0; regWEN/memRead/memWrite=0; data fields don't-care, drive 0). Go to BUBBLE if LOAD_STALL_CYCLES>1 with cnt=LOAD_STALL_CYCLES-1, otherwise stay in RUN.
- BUBBLE: stall_dec=1 and a bubble is latched each en cycle with cnt decremented. At cnt==1, latch the bubble and return to RUN; re-evaluate hz next cycle.
- flush=1 with en=1: latch a bubble and go to RUN with cnt=0. Flush has priority over hz and BUBBLE, and stall_dec=0.
- en=0: all registers, state and cnt hold. stall_dec still reflects hz/BUBBLE so decode does not advance.
- Simultaneous hz and flush: flush wins, so no stall.
- Rd==ZERO_REG never raises hz.
- Forward code 11 is treated as regfile.

Optional Feature:
- Macro IDEX_STALL_COUNT_EN.
- Defined: adds output stallCount (32) that increments on each en cycle where a hazard bubble is latched (not flush bubbles). It saturates at 32'hFFFFFFFF and resets to 0.
- Undefined: no port, no counter logic.

Decomposition:
- cpu_types_pkg gains word_t (32-bit), aluop_t (4-bit), regbits_t (already present), and packed struct id_ex_t holding every latched field plus valid.
- Also add enum idex_state_t {RUN, BUBBLE}.
- One sub-module: load_use_detect, purely combinational, outputs hz.
- Interface id_ex_latch_if with modports latch and tb, mirroring forwarding_unit_if.

Test Plan:
- Forwarding: forwardA=01, aluOut_ex=32'hDEAD_BEEF, en=1 -> next cycle opA_ex=32'hDEAD_BEEF. forwardB=10, wdat_mem=32'h1234 -> opB_ex=32'h1234.
- Load-use: EX holds lw, Rd_ex=8; decode Rs_dec=8; LOAD_STALL_CYCLES=1 -> stall_dec=1 for one cycle, valid_ex=0 next cycle, then the instruction latches with valid_ex=1.
- Multi-cycle: LOAD_STALL_CYCLES=3, same hazard -> three consecutive bubbles, stall_dec high 3 cycles. With en=0 for 2 cycles in between, stall_dec stays high 5 cycles total.
- Flush priority: hz=1 and flush=1 -> stall_dec=0, bubble latched, regWEN_ex=0.
- Zero register and usesRt: Rd_ex=0 lw -> no stall. Rt_dec match with usesRt_dec=0 -> no stall.
- Reset in BUBBLE: assert RST mid-stall -> outputs 0 asynchronously, stall_dec=0. With IDEX_STALL_COUNT_EN, stallCount=0 after reset and equals 3 after the multi-cycle test.
